// File: rtl/mux_arb_pipe_if.sv
// ============================================================================
// mux_arb_pipe_if : handshake/bus bundle for mux_arb_pipe (burst: MUX_ARB_BURST_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

interface mux_arb_pipe_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
);
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SEL_W-1:0]     out_src;
`ifdef MUX_ARB_BURST_EN
    logic [N-1:0]         in_last;
    logic                 out_last;

    modport master (
        output mode, sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_src, out_last
    );
    modport slave (
        input  mode, sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_src, out_last
    );
`else
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
`endif
endinterface

`default_nettype wire

// File: rtl/mux_arb_pipe.sv
// ============================================================================
// mux_arb_pipe : N-channel fixed/round-robin selector, one registered output
// stage. Optional burst locking when MUX_ARB_BURST_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module mux_arb_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mux_arb_pipe_if.slave  bus
);
    localparam int SEL_W = $clog2(N);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_src_q,   out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;
`ifdef MUX_ARB_BURST_EN
    logic             out_last_q,  out_last_d;
    logic             lock_q,      lock_d;
    logic [SEL_W-1:0] lock_idx_q,  lock_idx_d;
`endif

    logic             load_en;
    logic             grant_any;
    logic [SEL_W-1:0] grant_idx;
    logic [N-1:0]     ready_vec;
    logic             xfer;
    int               rr_idx;

    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
`ifdef MUX_ARB_BURST_EN
        // A locked burst owns the grant regardless of its current valid.
        if (lock_q) begin
            grant_any = 1'b1;
            grant_idx = lock_idx_q;
        end else
`endif
        if (!bus.mode) begin
            if (int'(bus.sel) < N && bus.in_valid[bus.sel]) begin
                grant_any = 1'b1;
                grant_idx = bus.sel;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                rr_idx = (int'(rr_ptr_q) + k) % N;
                if (!grant_any && bus.in_valid[rr_idx[SEL_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_idx[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        ready_vec            = '0;
        ready_vec[grant_idx] = grant_any & load_en;
    end

    assign xfer         = grant_any && load_en && bus.in_valid[grant_idx];
    assign bus.in_ready = ready_vec;

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef MUX_ARB_BURST_EN
        out_last_d  = out_last_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
`endif
        if (xfer) begin
            out_data_d  = bus.in_data[grant_idx*WIDTH +: WIDTH];
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            rr_ptr_d    = grant_idx;
`ifdef MUX_ARB_BURST_EN
            out_last_d  = bus.in_last[grant_idx];
            lock_d      = !bus.in_last[grant_idx];
            lock_idx_d  = grant_idx;
`endif
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SEL_W'(N - 1);
`ifdef MUX_ARB_BURST_EN
            out_last_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_ARB_BURST_EN
            out_last_q  <= out_last_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
`ifdef MUX_ARB_BURST_EN
    assign bus.out_last  = out_last_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_pipe.sv
// ============================================================================
// tb_mux_arb_pipe : directed self-checking bench for mux_arb_pipe. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_arb_pipe;
    localparam int WIDTH = 32;
    localparam int N     = 4;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    mux_arb_pipe_if #(.WIDTH(WIDTH), .N(N)) bus ();

    mux_arb_pipe #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [N*WIDTH-1:0] DFLT_DATA =
        {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.in_data   = DFLT_DATA;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
`ifdef MUX_ARB_BURST_EN
        bus.in_last   = '1;
`endif
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_src !== 2'd0) begin
            err_cnt++;
            $display("FAIL reset_state: valid=%b data=%h src=%0d, required 0/0/0",
                     bus.out_valid, bus.out_data, bus.out_src);
        end
        vec_cnt++;
        if (bus.in_ready !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_ready: in_ready=%b, required 0000", bus.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_src;
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1111;
        #1;
        vec_cnt++;
        if (bus.in_ready !== 4'b0001) begin
            err_cnt++;
            $display("FAIL rr_first_ready: in_ready=%b, required 0001", bus.in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_src = 2'(i % 4);
            vec_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_src !== exp_src ||
                bus.out_data !== (32'hCAFE0000 | 32'(exp_src))) begin
                err_cnt++;
                $display("FAIL rr_seq[%0d]: valid=%b src=%0d data=%h, required 1/%0d/%h",
                         i, bus.out_valid, bus.out_src, bus.out_data,
                         exp_src, 32'hCAFE0000 | 32'(exp_src));
            end
        end
        bus.in_valid = '0;
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_src !== 2'd0) begin
            err_cnt++;
            $display("FAIL rr_drain: valid=%b src=%0d, required 0/0", bus.out_valid, bus.out_src);
        end
    endtask

    task automatic test_fixed();
        bus.mode     = 1'b0;
        bus.sel      = 2'd2;
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++;
            if (bus.in_ready !== 4'b0100) begin
                err_cnt++;
                $display("FAIL fixed_ready[%0d]: in_ready=%b, required 0100", i, bus.in_ready);
            end
            tick();
            vec_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2 || bus.out_data !== 32'hCAFE0002) begin
                err_cnt++;
                $display("FAIL fixed_out[%0d]: valid=%b src=%0d data=%h, required 1/2/cafe0002",
                         i, bus.out_valid, bus.out_src, bus.out_data);
            end
        end
        bus.in_valid = '0;
        tick();
    endtask

    task automatic test_stall();
        bus.mode                 = 1'b0;
        bus.sel                  = 2'd2;
        bus.in_data[2*WIDTH +: WIDTH] = 32'hAAAA0002;
        bus.in_valid             = 4'b0100;
        bus.out_ready            = 1'b0;
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hAAAA0002) begin
            err_cnt++;
            $display("FAIL stall_capture: valid=%b data=%h, required 1/aaaa0002",
                     bus.out_valid, bus.out_data);
        end
        bus.in_data[2*WIDTH +: WIDTH] = 32'hBBBB0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++;
            if (bus.in_ready !== 4'b0000) begin
                err_cnt++;
                $display("FAIL stall_ready[%0d]: in_ready=%b, required 0000", i, bus.in_ready);
            end
            tick();
            vec_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hAAAA0002 || bus.out_src !== 2'd2) begin
                err_cnt++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h src=%0d, required 1/aaaa0002/2",
                         i, bus.out_valid, bus.out_data, bus.out_src);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        vec_cnt++;
        if (bus.in_ready !== 4'b0100) begin
            err_cnt++;
            $display("FAIL stall_release_ready: in_ready=%b, required 0100", bus.in_ready);
        end
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hBBBB0002) begin
            err_cnt++;
            $display("FAIL stall_replace: valid=%b data=%h, required 1/bbbb0002",
                     bus.out_valid, bus.out_data);
        end
        bus.in_valid = '0;
        bus.in_data  = DFLT_DATA;
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'hBBBB0002) begin
            err_cnt++;
            $display("FAIL stall_drain: valid=%b data=%h, required 0/bbbb0002",
                     bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_rr_sparse();
        logic [1:0] exp_src;
        // Park rr_ptr on channel 1 with a fixed-mode transfer.
        bus.mode     = 1'b0;
        bus.sel      = 2'd1;
        bus.in_valid = 4'b0010;
        tick();
        bus.in_valid = '0;
        tick();
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            exp_src = (i % 2 == 0) ? 2'd3 : 2'd1;
            #1;
            vec_cnt++;
            if (bus.in_ready[0] !== 1'b0 || bus.in_ready[2] !== 1'b0) begin
                err_cnt++;
                $display("FAIL sparse_ready[%0d]: in_ready=%b, required bits 0,2 clear",
                         i, bus.in_ready);
            end
            tick();
            vec_cnt++;
            if (bus.out_src !== exp_src || bus.out_valid !== 1'b1) begin
                err_cnt++;
                $display("FAIL sparse_src[%0d]: src=%0d valid=%b, required %0d/1",
                         i, bus.out_src, bus.out_valid, exp_src);
            end
        end
        bus.in_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.mode      = 1'b0;
        bus.sel       = 2'd2;
        bus.in_data[2*WIDTH +: WIDTH] = 32'h12345678;
        bus.in_valid  = 4'b0100;
        bus.out_ready = 1'b0;
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h12345678) begin
            err_cnt++;
            $display("FAIL rstmid_load: valid=%b data=%h, required 1/12345678",
                     bus.out_valid, bus.out_data);
        end
        #2;
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_src !== 2'd0) begin
            err_cnt++;
            $display("FAIL rstmid_clear: valid=%b data=%h src=%0d, required 0/0/0",
                     bus.out_valid, bus.out_data, bus.out_src);
        end
        @(negedge clk);
        reset         = 1'b0;
        bus.in_data   = DFLT_DATA;
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0 || bus.out_data !== 32'hCAFE0000) begin
            err_cnt++;
            $display("FAIL rstmid_first: valid=%b src=%0d data=%h, required 1/0/cafe0000",
                     bus.out_valid, bus.out_src, bus.out_data);
        end
        bus.in_valid = '0;
        tick();
    endtask

`ifdef MUX_ARB_BURST_EN
    task automatic test_burst();
        logic [1:0] exp_src [4];
        logic       exp_last[4];
        exp_src  = '{2'd2, 2'd2, 2'd2, 2'd0};
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
        // rr_ptr is 0 here, so channel 2 wins the first beat over channel 0.
        bus.mode     = 1'b1;
        bus.in_valid = 4'b0101;
        bus.in_last  = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) bus.in_last = 4'b1111;
            if (i == 1 || i == 2) begin
                #1;
                vec_cnt++;
                if (bus.in_ready !== 4'b0100) begin
                    err_cnt++;
                    $display("FAIL burst_ready[%0d]: in_ready=%b, required 0100", i, bus.in_ready);
                end
            end
            tick();
            vec_cnt++;
            if (bus.out_src !== exp_src[i] || bus.out_last !== exp_last[i] || bus.out_valid !== 1'b1) begin
                err_cnt++;
                $display("FAIL burst_beat[%0d]: src=%0d last=%b valid=%b, required %0d/%b/1",
                         i, bus.out_src, bus.out_last, bus.out_valid, exp_src[i], exp_last[i]);
            end
        end
        bus.in_valid = '0;
        tick();
    endtask
`endif

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_round_robin();
        test_fixed();
        test_stall();
        test_rr_sparse();
        test_reset_mid();
`ifdef MUX_ARB_BURST_EN
        test_burst();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mux_arb_pipe.md
Name: mux_arb_pipe

Overview:
Parametrised N-channel, WIDTH-bit selector for the datapath.
- Each input and the output carry a valid/ready handshake.
- Two arbitration modes: fixed select (the index picks the channel) or round-robin among requesting channels.
- One registered output stage with full throughput.
- Intended to merge write-back, forwarding and memory-response channels in the processor.

Parameters:
WIDTH, 32, data width per channel in bits
N, 4, number of input channels (N >= 2)
SEL_W, $clog2(N), width of select and source index (derived; do not override)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
mode  in  1  0 = fixed select via sel, 1 = round-robin
sel  in  SEL_W  channel index used when mode = 0
in_data  in  N*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  in  N  per-channel valid
in_ready  out  N  per-channel ready; at most one bit set
out_data  out  WIDTH  registered output data
out_valid  out  1  output register holds a word
out_ready  in  1  downstream accepts the word
out_src  out  SEL_W  index of the channel that produced out_data

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0, out_src=0, rr_ptr=N-1. With rr_ptr=N-1, channel 0 has the highest priority first.
- load_en = !out_valid || out_ready. This gives full throughput: one word per cycle with no bubble.
- Grant is combinational from in_valid, mode, sel and rr_ptr. in_ready[i] = grant[i] & load_en.
- Fixed mode (mode=0): grant[sel] = in_valid[sel]; all other channels get ready=0.
- Fixed mode, sel >= N: no grant, and out_valid must not assert.
- Round-robin mode (mode=1): search order is rr_ptr+1, rr_ptr+2, ... wrapping modulo N. Grant the first channel with valid=1.
- Transfer on channel i = in_valid[i] & in_ready[i]. On the same edge:
  - out_data <= channel i data, out_src <= i, out_valid <= 1.
  - rr_ptr <= i. rr_ptr updates in both modes.
- When out_valid & out_ready and no transfer occurs: out_valid <= 0. out_data and out_src keep their last value.
- Stall (out_valid & !out_ready): out_data, out_src and out_valid hold stable; all in_ready = 0.
- Latency: an input accepted at edge k is visible on out_* after edge k. One cycle from acceptance to out_valid.
- mode and sel are sampled every cycle and take effect on the next arbitration. Words already in the output register are unaffected.
- Simultaneous output drain and new acceptance in the same cycle: the register is replaced, out_valid stays 1.
- Reset asserted mid-transfer: the output word is discarded immediately. Inputs must re-present after reset deasserts.
- No combinational path from out_ready to out_data. The path out_ready -> in_ready is allowed.

Optional Feature:
Macro: MUX_ARB_BURST_EN.
- Defined:
  - Adds ports in_last (in, N) and out_last (out, 1). out_last is registered with out_data and resets to 0.
  - A transfer with in_last[i]=0 locks the grant to channel i, ignoring mode, sel and the other channels, until a transfer on i with in_last[i]=1.
  - The lock clears on reset.
  - While locked, channel i's in_ready follows load_en even if mode/sel would select another channel.
- Not defined: no in_last/out_last ports; every transfer arbitrates independently as described above.

Test Plan:
- Reset, then mode=1, in_valid=4'b1111, out_ready=1 held. Required: out_src sequence 0,1,2,3,0 on consecutive cycles; out_valid=1 continuously from the first edge after the request.
- mode=0, sel=2, in_valid=4'b1111, ch2 data 0xCAFE0002. Required: only in_ready[2]=1; out_data=0xCAFE0002, out_src=2 every cycle.
- mode=0, sel=2, ch2 valid, out_ready=0 for 3 cycles then 1. Required:
  - First word is captured.
  - in_ready=0 and out_data stable for 3 cycles.
  - The next word is accepted in the same cycle the first drains.
- mode=1, only ch1 and ch3 valid, rr_ptr=1. Required: grant order 3,1,3,1; ch0 and ch2 always in_ready=0.
- Reset pulsed while out_valid=1 holding 0x12345678. Required: out_valid=0, out_data=0, out_src=0 immediately; after release with all four channels valid, the first grant is ch0.
- With MUX_ARB_BURST_EN defined: ch2 sends a 3-beat burst (last on beat 3) while ch0 is also valid, mode=1. Required: out_src=2,2,2 with out_last=0,0,1, then out_src=0.
